// File: rtl/iua_usb_rx_frontend_if.sv
// Pad inputs and framed bit-stream outputs of the full-speed USB receive front end.
// The front end is the master of the decoded stream; the capture path is the slave.
interface iua_usb_rx_frontend_if;
    logic       pad_dp;
    logic       pad_dn;
    logic [1:0] ls_state;
    logic       out_bit;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       out_err;
    logic       active;

    modport master (
        input  pad_dp, pad_dn,
        output ls_state, out_bit, out_valid, out_sop, out_eop, out_err, active
    );

    modport slave (
        output pad_dp, pad_dn,
        input  ls_state, out_bit, out_valid, out_sop, out_eop, out_err, active
    );
endinterface

// File: rtl/iua_usb_rx_frontend.sv
// Full-speed USB receive front end: pad sync, 4x DPLL, NRZI decode, SYNC detect,
// bit unstuffing and EOP detection, producing a framed unstuffed bit stream.
module iua_usb_rx_frontend #(
    parameter int unsigned SYNC_MIN_ZEROS = 5,
    parameter int unsigned STUFF_LEN      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    iua_usb_rx_frontend_if.master bus
);
    localparam int unsigned OW = $clog2(STUFF_LEN + 1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;

    logic          dp_s1, dp_s2, dn_s1, dn_s2;
    logic [1:0]    ls, ls_prev, prev_sym;
    logic [1:0]    phase;
    logic          line_edge, strobe, sym_jk, nrzi_bit;
    state_t        state, state_n;
    logic [2:0]    zero_cnt, zero_cnt_n;
    logic [OW-1:0] ones_cnt, ones_cnt_n;
    logic          valid_n, bit_n, sop_n, eop_n, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_s1 <= 1'b1;
            dp_s2 <= 1'b1;
            dn_s1 <= 1'b0;
            dn_s2 <= 1'b0;
        end else begin
            dp_s1 <= bus.pad_dp;
            dp_s2 <= dp_s1;
            dn_s1 <= bus.pad_dn;
            dn_s2 <= dn_s1;
        end
    end

    assign ls           = {dp_s2, dn_s2};
    assign bus.ls_state = ls;
    assign line_edge    = (ls != ls_prev);
    // Gating with the edge keeps a stale mid-bit strobe from landing on a fresh transition.
    assign strobe       = (phase == 2'd1) && !line_edge;
    assign sym_jk       = (ls == LS_J) || (ls == LS_K);
    assign nrzi_bit     = (ls == prev_sym);

    always_ff @(posedge clk) begin
        if (rst) begin
            ls_prev <= LS_J;
            phase   <= '0;
        end else begin
            ls_prev <= ls;
            phase   <= line_edge ? 2'd0 : phase + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sym <= LS_J;
        end else if (state == IDLE) begin
            prev_sym <= (strobe && ls == LS_K) ? LS_K : LS_J;
        end else if (strobe && sym_jk) begin
            prev_sym <= ls;
        end
    end

    always_comb begin
        state_n    = state;
        zero_cnt_n = zero_cnt;
        ones_cnt_n = ones_cnt;
        valid_n    = 1'b0;
        bit_n      = 1'b0;
        sop_n      = 1'b0;
        eop_n      = 1'b0;
        err_n      = 1'b0;
        if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (ls == LS_K) begin
                        state_n    = SYNC;
                        zero_cnt_n = 3'd1;
                    end
                end
                SYNC: begin
                    if (ls == LS_SE1) begin
                        state_n = ABORT;
                        err_n   = 1'b1;
                    end else if (ls == LS_SE0) begin
                        state_n = IDLE;
                    end else if (!nrzi_bit) begin
                        zero_cnt_n = (zero_cnt == 3'd7) ? 3'd7 : zero_cnt + 3'd1;
                    end else if (zero_cnt >= 3'(SYNC_MIN_ZEROS)) begin
                        state_n    = DATA;
                        sop_n      = 1'b1;
                        ones_cnt_n = OW'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    if (ls == LS_SE0) begin
                        state_n = EOP;
                    end else if (ls == LS_SE1) begin
                        state_n = ABORT;
                        err_n   = 1'b1;
                    end else if (ones_cnt == OW'(STUFF_LEN)) begin
                        if (nrzi_bit) begin
                            state_n = ABORT;
                            err_n   = 1'b1;
                        end else begin
                            ones_cnt_n = '0;
                        end
                    end else begin
                        valid_n    = 1'b1;
                        bit_n      = nrzi_bit;
                        ones_cnt_n = nrzi_bit ? ones_cnt + OW'(1) : '0;
                    end
                end
                EOP: begin
                    if (ls == LS_J) begin
                        state_n = IDLE;
                        eop_n   = 1'b1;
                    end else if (ls != LS_SE0) begin
                        state_n = ABORT;
                        err_n   = 1'b1;
                    end
                end
                ABORT: begin
                    if (ls == LS_J) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            zero_cnt      <= '0;
            ones_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_bit   <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.active    <= 1'b0;
        end else begin
            state         <= state_n;
            zero_cnt      <= zero_cnt_n;
            ones_cnt      <= ones_cnt_n;
            bus.out_valid <= valid_n;
            bus.out_bit   <= bit_n;
            bus.out_sop   <= sop_n;
            bus.out_eop   <= eop_n;
            bus.out_err   <= err_n;
            bus.active    <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_iua_usb_rx_frontend.sv
// Directed bench for the USB receive front end: NRZI-encoded packets driven on the pads,
// output pulses collected on the falling edge and compared with hand-derived values.
module tb_iua_usb_rx_frontend;
    logic clk = 1'b0;
    logic rst;

    iua_usb_rx_frontend_if bus ();

    iua_usb_rx_frontend #(
        .SYNC_MIN_ZEROS(5),
        .STUFF_LEN(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Output collector
    bit rx_bits[$];
    int sop_cnt, eop_cnt, err_cnt, valid_at_err, active_hi, eop_active;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) rx_bits.push_back(bus.out_bit);
        if (bus.out_sop === 1'b1) sop_cnt++;
        if (bus.out_eop === 1'b1) begin
            eop_cnt++;
            if (bus.active === 1'b1) eop_active++;
        end
        if (bus.out_err === 1'b1) begin
            err_cnt++;
            valid_at_err = rx_bits.size();
        end
        if (bus.active === 1'b1) active_hi++;
    end

    task automatic clear_mon();
        rx_bits.delete();
        sop_cnt = 0; eop_cnt = 0; err_cnt = 0;
        valid_at_err = -1; active_hi = 0; eop_active = 0;
    endtask

    // Transmit side
    bit   tx[$];
    logic line_j;
    int   sym_idx;
    bit   jitter;

    task automatic drive_sym(input logic [1:0] s);
        int n;
        n = jitter ? ((sym_idx % 2 == 0) ? 3 : 5) : 4;
        sym_idx++;
        bus.pad_dp = s[1];
        bus.pad_dn = s[0];
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_j(input int n);
        bus.pad_dp = 1'b1;
        bus.pad_dn = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_sync();
        tx.delete();
        for (int i = 0; i < 7; i++) tx.push_back(1'b0);
        tx.push_back(1'b1);
    endtask

    task automatic load_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx.push_back(b[i]);
    endtask

    // tail: 0 = EOP then idle J, 1 = idle J only, 2 = leave line as is
    task automatic send_packet(input int tail);
        line_j  = 1'b1;
        sym_idx = 0;
        foreach (tx[i]) begin
            if (tx[i] == 1'b0) line_j = ~line_j;
            drive_sym(line_j ? 2'b10 : 2'b01);
        end
        if (tail == 0) begin
            drive_sym(2'b00);
            drive_sym(2'b00);
            drive_sym(2'b10);
        end
        if (tail != 2) idle_j(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pad_dp = 1'b1;
        bus.pad_dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ls_state !== 2'b10) begin
            errors++; $display("FAIL reset_ls: got %b want 10", bus.ls_state);
        end
        checks++;
        if ({bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop, bus.out_err} !== 5'b0) begin
            errors++; $display("FAIL reset_out: got %b want 00000",
                {bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop, bus.out_err});
        end
        checks++;
        if (bus.active !== 1'b0) begin
            errors++; $display("FAIL reset_active: got %b want 0", bus.active);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_se0();
        clear_mon();
        idle_j(200);
        checks++;
        if (bus.ls_state !== 2'b10) begin
            errors++; $display("FAIL idle_ls_j: got %b want 10", bus.ls_state);
        end
        bus.pad_dp = 1'b0;
        bus.pad_dn = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (bus.ls_state !== 2'b00) begin
            errors++; $display("FAIL idle_ls_se0: got %b want 00", bus.ls_state);
        end
        idle_j(20);
        checks++;
        if (sop_cnt + eop_cnt + err_cnt + rx_bits.size() !== 0) begin
            errors++; $display("FAIL idle_pulses: got sop=%0d eop=%0d err=%0d valid=%0d want all 0",
                sop_cnt, eop_cnt, err_cnt, rx_bits.size());
        end
        checks++;
        if (active_hi !== 0) begin
            errors++; $display("FAIL idle_active: got %0d active cycles want 0", active_hi);
        end
    endtask

    task automatic test_byte_a5(input bit jit);
        logic [15:0] got;
        string tag;
        tag = jit ? "jit" : "a5";
        jitter = jit;
        clear_mon();
        load_sync();
        load_byte(8'hA5);
        send_packet(0);
        jitter = 1'b0;
        got = '0;
        foreach (rx_bits[i]) if (i < 16) got[i] = rx_bits[i];
        checks++;
        if (sop_cnt !== 1) begin
            errors++; $display("FAIL %s_sop: got %0d want 1", tag, sop_cnt);
        end
        checks++;
        if (rx_bits.size() !== 8) begin
            errors++; $display("FAIL %s_count: got %0d want 8", tag, rx_bits.size());
        end
        checks++;
        if (got !== 16'h00A5) begin
            errors++; $display("FAIL %s_bits: got %h want 00a5", tag, got);
        end
        checks++;
        if (eop_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL %s_eop_err: got eop=%0d err=%0d want eop=1 err=0", tag, eop_cnt, err_cnt);
        end
        checks++;
        if (eop_active !== 0 || active_hi == 0 || bus.active !== 1'b0) begin
            errors++; $display("FAIL %s_active: got at_eop=%0d hi_cycles=%0d now=%b want 0,>0,0",
                tag, eop_active, active_hi, bus.active);
        end
    endtask

    task automatic test_stuffing();
        logic [15:0] got;
        clear_mon();
        load_sync();
        for (int i = 0; i < 5; i++) tx.push_back(1'b1);
        tx.push_back(1'b0);
        for (int i = 0; i < 6; i++) tx.push_back(1'b1);
        tx.push_back(1'b0);
        for (int i = 0; i < 5; i++) tx.push_back(1'b1);
        send_packet(0);
        got = '0;
        foreach (rx_bits[i]) if (i < 16) got[i] = rx_bits[i];
        checks++;
        if (rx_bits.size() !== 16) begin
            errors++; $display("FAIL stuff_count: got %0d want 16", rx_bits.size());
        end
        checks++;
        if (got !== 16'hFFFF) begin
            errors++; $display("FAIL stuff_bits: got %h want ffff", got);
        end
        checks++;
        if (err_cnt !== 0) begin
            errors++; $display("FAIL stuff_err: got %0d want 0", err_cnt);
        end
        checks++;
        if (eop_cnt !== 1 || sop_cnt !== 1) begin
            errors++; $display("FAIL stuff_frame: got sop=%0d eop=%0d want 1,1", sop_cnt, eop_cnt);
        end
    endtask

    task automatic test_stuff_violation();
        clear_mon();
        load_sync();
        for (int i = 0; i < 7; i++) tx.push_back(1'b1);
        send_packet(1);
        checks++;
        if (err_cnt !== 1) begin
            errors++; $display("FAIL viol_err: got %0d want 1", err_cnt);
        end
        checks++;
        if (valid_at_err !== 5) begin
            errors++; $display("FAIL viol_err_pos: got %0d valid before err want 5", valid_at_err);
        end
        checks++;
        if (rx_bits.size() !== 5) begin
            errors++; $display("FAIL viol_count: got %0d want 5", rx_bits.size());
        end
        checks++;
        if (eop_cnt !== 0) begin
            errors++; $display("FAIL viol_eop: got %0d want 0", eop_cnt);
        end
        checks++;
        if (bus.active !== 1'b0) begin
            errors++; $display("FAIL viol_active: got %b want 0", bus.active);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [15:0] got;
        clear_mon();
        load_sync();
        tx.push_back(1'b1); tx.push_back(1'b0); tx.push_back(1'b1); tx.push_back(1'b0);
        send_packet(2);
        repeat (2) @(posedge clk);
        #1;
        bus.pad_dp = 1'b1;
        bus.pad_dn = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop, bus.out_err, bus.active} !== 6'b0) begin
            errors++; $display("FAIL rst_mid_out: got %b want 000000",
                {bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop, bus.out_err, bus.active});
        end
        checks++;
        if (bus.ls_state !== 2'b10) begin
            errors++; $display("FAIL rst_mid_ls: got %b want 10", bus.ls_state);
        end
        got = '0;
        foreach (rx_bits[i]) if (i < 16) got[i] = rx_bits[i];
        checks++;
        if (rx_bits.size() !== 4 || got !== 16'h0005) begin
            errors++; $display("FAIL rst_mid_pre: got %0d bits %h want 4 bits 0005", rx_bits.size(), got);
        end
        idle_j(20);
        checks++;
        if (eop_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL rst_mid_pulses: got eop=%0d err=%0d want 0,0", eop_cnt, err_cnt);
        end
        clear_mon();
        load_sync();
        load_byte(8'hA5);
        send_packet(0);
        got = '0;
        foreach (rx_bits[i]) if (i < 16) got[i] = rx_bits[i];
        checks++;
        if (sop_cnt !== 1) begin
            errors++; $display("FAIL rst_post_sop: got %0d want 1", sop_cnt);
        end
        checks++;
        if (rx_bits.size() !== 8 || got !== 16'h00A5) begin
            errors++; $display("FAIL rst_post_bits: got %0d bits %h want 8 bits 00a5", rx_bits.size(), got);
        end
        checks++;
        if (eop_cnt !== 1 || err_cnt !== 0) begin
            errors++; $display("FAIL rst_post_eop: got eop=%0d err=%0d want 1,0", eop_cnt, err_cnt);
        end
    endtask

    initial begin
        jitter = 1'b0;
        clear_mon();
        test_reset();
        test_idle_se0();
        test_byte_a5(1'b0);
        test_stuffing();
        test_stuff_violation();
        test_byte_a5(1'b1);
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
